// File: rtl/writeback_unit_if.sv
// Bundle of the writeback stage's ALU, load-response and register-file write signals.
// The master side drives the ALU and load inputs. The slave side is the writeback unit.
interface writeback_unit_if #(parameter int CNT_W = 3);
  logic             alu_valid;
  logic             alu_ready;
  logic [4:0]       alu_rd;
  logic [31:0]      alu_result;
  logic             ld_valid;
  logic [4:0]       ld_rd;
  logic [31:0]      ld_data;
  logic [2:0]       ld_funct3;
  logic [1:0]       ld_addr_lo;
  logic             w_en;
  logic [4:0]       wd;
  logic [31:0]      wdata;
  logic [CNT_W-1:0] alu_count;
  logic [31:0]      instret;

  modport master (
    output alu_valid, alu_rd, alu_result,
    output ld_valid, ld_rd, ld_data, ld_funct3, ld_addr_lo,
    input  alu_ready, w_en, wd, wdata, alu_count, instret
  );

  modport slave (
    input  alu_valid, alu_rd, alu_result,
    input  ld_valid, ld_rd, ld_data, ld_funct3, ld_addr_lo,
    output alu_ready, w_en, wd, wdata, alu_count, instret
  );
endinterface

// File: rtl/writeback_unit.sv
// Final pipeline stage: merges loads (never stalled) with FIFO-buffered ALU results
// onto one registered register-file write port, and counts retired instructions.
module writeback_unit #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic            clk,
  input  logic            rst,
  writeback_unit_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [36:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q;
  logic             w_en_q;
  logic [4:0]       wd_q;
  logic [31:0]      wdata_q;
  logic [31:0]      instret_q;

  logic             ready_s, accept_s, push_s, pop_s, sel_valid_s;
  logic [4:0]       sel_rd_s;
  logic [31:0]      sel_data_s;

  function automatic logic [31:0] format_load(input logic [31:0] data,
                                              input logic [2:0]  funct3,
                                              input logic [1:0]  addr_lo);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    byte_v = data[8*addr_lo +: 8];
    half_v = addr_lo[1] ? data[31:16] : data[15:0];
    case (funct3)
      3'b000:  format_load = {{24{byte_v[7]}}, byte_v};
      3'b001:  format_load = {{16{half_v[15]}}, half_v};
      3'b100:  format_load = {24'd0, byte_v};
      3'b101:  format_load = {16'd0, half_v};
      default: format_load = data;
    endcase
  endfunction

  // Readiness looks only at registered occupancy, so a full FIFO refuses even while popping.
  always_comb begin
    ready_s     = !rst && (count_q < CNT_W'(FIFO_DEPTH));
    accept_s    = bus.alu_valid && ready_s;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    sel_valid_s = 1'b1;
    sel_rd_s    = 5'd0;
    sel_data_s  = 32'd0;
    if (bus.ld_valid) begin
      sel_rd_s   = bus.ld_rd;
      sel_data_s = format_load(bus.ld_data, bus.ld_funct3, bus.ld_addr_lo);
      push_s     = accept_s;
    end else if (count_q != '0) begin
      sel_rd_s   = mem_q[rptr_q][36:32];
      sel_data_s = mem_q[rptr_q][31:0];
      pop_s      = 1'b1;
      push_s     = accept_s;
    end else if (accept_s) begin
      sel_rd_s   = bus.alu_rd;
      sel_data_s = bus.alu_result;
    end else begin
      sel_valid_s = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_en_q    <= 1'b0;
      wd_q      <= 5'd0;
      wdata_q   <= 32'd0;
      instret_q <= 32'd0;
      count_q   <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
    end else begin
      // x0 writes still retire and update wd/wdata, only the enable is masked.
      w_en_q <= sel_valid_s && (sel_rd_s != 5'd0);
      if (sel_valid_s) begin
        wd_q      <= sel_rd_s;
        wdata_q   <= sel_data_s;
        instret_q <= instret_q + 32'd1;
      end
      if (push_s) begin
        mem_q[wptr_q] <= {bus.alu_rd, bus.alu_result};
        wptr_q        <= wptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rptr_q <= rptr_q + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.alu_ready = ready_s;
  assign bus.w_en      = w_en_q;
  assign bus.wd        = wd_q;
  assign bus.wdata     = wdata_q;
  assign bus.alu_count = count_q;
  assign bus.instret   = instret_q;
endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios then random traffic,
// compared each cycle against a queue-based reference model.
module tb_writeback_unit;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  writeback_unit_if #(.CNT_W(3)) bus ();

  writeback_unit #(.FIFO_DEPTH(DEPTH), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [36:0] m_fifo[$];
  logic        m_wen;
  logic [4:0]  m_wd;
  logic [31:0] m_wdata;
  logic [31:0] m_instret;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [2:0] f3,
                                           input logic [1:0] lo);
    logic [31:0] b, h;
    b = (d >> (8 * lo)) & 32'hFF;
    h = (d >> (16 * lo[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return d;
    endcase
  endfunction

  // One clock cycle: drive inputs, check readiness, advance the model, check registered outputs.
  task automatic step(input logic r, input logic av, input logic [4:0] ard, input logic [31:0] ares,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                      input logic [2:0] f3, input logic [1:0] lo);
    logic        rdy, acc, cand;
    logic [36:0] c;
    @(negedge clk);
    rst = r;
    bus.alu_valid = av; bus.alu_rd = ard; bus.alu_result = ares;
    bus.ld_valid = lv; bus.ld_rd = lrd; bus.ld_data = ldat;
    bus.ld_funct3 = f3; bus.ld_addr_lo = lo;
    #1;
    rdy = !r && (m_fifo.size() < DEPTH);
    check_eq("alu_ready", {31'd0, bus.alu_ready}, {31'd0, rdy});
    if (r) begin
      m_fifo.delete();
      m_wen = 1'b0; m_wd = 5'd0; m_wdata = 32'd0; m_instret = 32'd0;
    end else begin
      acc  = av && rdy;
      cand = 1'b1;
      if (lv) begin
        c = {lrd, ref_load(ldat, f3, lo)};
        if (acc) m_fifo.push_back({ard, ares});
      end else if (m_fifo.size() > 0) begin
        c = m_fifo.pop_front();
        if (acc) m_fifo.push_back({ard, ares});
      end else if (acc) begin
        c = {ard, ares};
      end else begin
        cand = 1'b0;
        c = 37'd0;
      end
      m_wen = cand && (c[36:32] != 5'd0);
      if (cand) begin
        m_wd = c[36:32]; m_wdata = c[31:0]; m_instret = m_instret + 32'd1;
      end
    end
    @(posedge clk);
    #1;
    check_eq("w_en", {31'd0, bus.w_en}, {31'd0, m_wen});
    check_eq("wd", {27'd0, bus.wd}, {27'd0, m_wd});
    check_eq("wdata", bus.wdata, m_wdata);
    check_eq("alu_count", {29'd0, bus.alu_count}, m_fifo.size());
    check_eq("instret", bus.instret, m_instret);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
  endtask

  task automatic load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] exp);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h80F0_7F81, f3, lo);
    check_eq("load_const", bus.wdata, exp);
  endtask

  initial begin
    m_wen = 1'b0; m_wd = 5'd0; m_wdata = 32'd0; m_instret = 32'd0;
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1, 3'd2, 2'd0);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
    check_eq("reset_instret", bus.instret, 32'd0);

    // ALU only
    step(1'b0, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
    check_eq("alu_only_wdata", bus.wdata, 32'h0000_1234);
    check_eq("alu_only_instret", bus.instret, 32'd1);
    idle(1);

    // Load formatting
    load(3'b000, 2'd0, 32'hFFFF_FF81);
    load(3'b100, 2'd3, 32'h0000_0080);
    load(3'b001, 2'd2, 32'hFFFF_80F0);
    load(3'b101, 2'd1, 32'h0000_7F81);
    load(3'b010, 2'd0, 32'h80F0_7F81);
    load(3'b111, 2'd1, 32'h80F0_7F81);

    // Pre-emption: five loads alongside ALU rd=1..5, rd=5 held until accepted
    for (int i = 1; i <= 5; i++)
      step(1'b0, 1'b1, 5'(i), 32'(i * 16), 1'b1, 5'(i + 10), 32'(i), 3'd2, 2'd0);
    check_eq("preempt_full", {29'd0, bus.alu_count}, 32'd4);
    step(1'b0, 1'b1, 5'd5, 32'd80, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
    check_eq("preempt_head", {27'd0, bus.wd}, 32'd1);
    step(1'b0, 1'b1, 5'd5, 32'd80, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
    idle(6);

    // x0 suppression
    step(1'b0, 1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
    check_eq("x0_alu_wen", {31'd0, bus.w_en}, 32'd0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55, 3'd2, 2'd0);
    check_eq("x0_ld_wen", {31'd0, bus.w_en}, 32'd0);

    // Simultaneous push/pop with two entries buffered
    step(1'b0, 1'b1, 5'd8, 32'h8, 1'b1, 5'd20, 32'h1, 3'd2, 2'd0);
    step(1'b0, 1'b1, 5'd9, 32'h9, 1'b1, 5'd21, 32'h2, 3'd2, 2'd0);
    step(1'b0, 1'b1, 5'd10, 32'hA, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
    check_eq("pushpop_count", {29'd0, bus.alu_count}, 32'd2);
    idle(3);

    // Reset mid-stream with three entries buffered
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 5'(i + 12), 32'(i), 1'b1, 5'd22, 32'h3, 3'd2, 2'd0);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
    check_eq("midrst_count", {29'd0, bus.alu_count}, 32'd0);
    idle(3);

    // Random traffic
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)),
           $urandom, ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom,
           3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
    idle(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
